pipe_hazard_ctrl: RTL and testbench

//   Hazard/issue controller for the 5-stage pipeline; sits in ID and drives the ID/EX register.

---
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - ID-stage hazard/issue controller: forwarding, load-use and mul/div stalls
//
// Purpose:
//   Sits in ID and drives the ID/EX register. Produces operand forwarding
//   selects and detects load-use hazards. Sequences the multi-cycle mul/div
//   unit with a busy scoreboard. Generates the PC/IF-ID write enable and the
//   ID/EX bubble control. Keeps a saturating stall-cycle counter.
//
// Ports:
//   clk, clrn               clock (rising edge), asynchronous active-low reset
//   rs, rt, use_rs, use_rt  ID-stage source registers and their read enables
//   d_md, d_mdrd            ID instruction starts mul/div / reads HI-LO
//   ern, ewreg, em2reg      EX-stage destination, write enable, load flag
//   mrn, mwreg, mm2reg      MEM-stage destination, write enable, load flag
//   fwda, fwdb              operand selects: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load
//   wpcir                   1 = PC and IF/ID update, 0 = hold
//   dbubble                 1 = squash the instruction entering ID/EX
//   md_busy, md_done        mul/div occupied / one-cycle result-ready pulse
//   stall_cnt               saturating count of stalled cycles

module pipe_hazard_ctrl #(
  parameter int MD_LAT = 8,
  parameter int CNTW   = 4,
  parameter int PERFW  = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             d_md,
  input  logic             d_mdrd,
  input  logic [4:0]       ern,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       mrn,
  input  logic             mwreg,
  input  logic             mm2reg,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             dbubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [PERFW-1:0] stall_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  // Counter is loaded with MD_LAT-1 so that the exit edge is the MD_LAT-th
  // edge after the issue edge.
  localparam logic [CNTW-1:0]  MD_INIT  = CNTW'(MD_LAT - 1);
  localparam logic [PERFW-1:0] PERF_MAX = '1;

  md_state_e        state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             md_busy_q, md_busy_d;
  logic             md_done_q, md_done_d;
  logic [PERFW-1:0] stall_cnt_q, stall_cnt_d;

  logic lu;
  logic mdh;
  logic stall;

  // EX match is tested first so a younger producer always wins over MEM.
  // Register 0 is hard-wired zero and must never be forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if (ewreg && !em2reg && (ern == src)) begin
        sel = 2'b01;
      end else if (mwreg && !mm2reg && (mrn == src)) begin
        sel = 2'b10;
      end else if (mwreg && mm2reg && (mrn == src)) begin
        sel = 2'b11;
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwda = fwd_sel(rs);
    fwdb = fwd_sel(rt);
  end

  // A load in EX cannot forward yet; the consumer waits one cycle and then
  // picks the data up from MEM via select 11.
  always_comb begin
    lu = ewreg && em2reg && (ern != 5'd0) &&
         ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));
    // While busy, both a second start and a HI/LO read must wait.
    mdh   = md_busy_q && (d_md || d_mdrd);
    stall = lu || mdh;
  end

  assign wpcir   = ~stall;
  assign dbubble = stall;

  // Mul/div sequencer. In BUSY mdh holds any new start, so the exit edge
  // never overlaps an issue; the next start can go one cycle later.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_busy_d = md_busy_q;
    md_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_md && !stall) begin
          state_d   = S_BUSY;
          cnt_d     = MD_INIT;
          md_busy_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d   = S_IDLE;
          md_busy_d = 1'b0;
          md_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        md_busy_d = 1'b0;
      end
    endcase
  end

  // Saturates at all-ones so long stalls never read back as short ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != PERF_MAX)) begin
      stall_cnt_d = stall_cnt_q + PERFW'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      md_busy_q   <= 1'b0;
      md_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_busy_q   <= md_busy_d;
      md_done_q   <= md_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_busy   = md_busy_q;
  assign md_done   = md_done_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

  localparam int MD_LAT = 8;
  localparam int CNTW   = 4;
  localparam int PERFW  = 4;
  localparam int PMAX   = (1 << PERFW) - 1;

  localparam int S_FWDA  = 0;
  localparam int S_FWDB  = 1;
  localparam int S_WPCIR = 2;
  localparam int S_BUBL  = 3;
  localparam int S_BUSY  = 4;
  localparam int S_DONE  = 5;
  localparam int S_SCNT  = 6;

  logic             clk = 1'b0;
  logic             clrn;
  logic [4:0]       rs, rt, ern, mrn;
  logic             use_rs, use_rt, d_md, d_mdrd;
  logic             ewreg, em2reg, mwreg, mm2reg;
  logic [1:0]       fwda, fwdb;
  logic             wpcir, dbubble, md_busy, md_done;
  logic [PERFW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNTW(CNTW), .PERFW(PERFW)) dut (
    .clk(clk), .clrn(clrn),
    .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .d_md(d_md), .d_mdrd(d_mdrd),
    .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
    .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
    .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .dbubble(dbubble),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model of the registered state, advanced once per rising edge.
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_left = 0;
  int m_cnt  = 0;

  function automatic logic [31:0] obs(input int s);
    case (s)
      S_FWDA:  return 32'(fwda);
      S_FWDB:  return 32'(fwdb);
      S_WPCIR: return 32'(wpcir);
      S_BUBL:  return 32'(dbubble);
      S_BUSY:  return 32'(md_busy);
      S_DONE:  return 32'(md_done);
      default: return 32'(stall_cnt);
    endcase
  endfunction

  function automatic bit m_lu();
    return ewreg && em2reg && (ern != 5'd0) &&
           ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));
  endfunction

  function automatic bit m_stall();
    return m_lu() || (m_busy && (d_md || d_mdrd));
  endfunction

  task automatic push(input string tag, input int s, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sig = s;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic push_model(input string tag);
    push({tag, "_busy"}, S_BUSY, 32'(m_busy));
    push({tag, "_done"}, S_DONE, 32'(m_done));
    push({tag, "_scnt"}, S_SCNT, 32'(m_cnt));
    push({tag, "_wpcir"}, S_WPCIR, 32'(!m_stall()));
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_left = 0;
    m_cnt  = 0;
  endtask

  task automatic clear_in();
    rs = 5'd0; rt = 5'd0; ern = 5'd0; mrn = 5'd0;
    use_rs = 1'b0; use_rt = 1'b0; d_md = 1'b0; d_mdrd = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; mwreg = 1'b0; mm2reg = 1'b0;
  endtask

  // Advance one clock: model sees the inputs present at the edge, then
  // inputs may be changed 1 time unit after the edge.
  task automatic tick();
    bit st;
    bit md;
    st = m_stall();
    md = d_md;
    @(posedge clk);
    if (!clrn) begin
      model_reset();
    end else begin
      if (st && (m_cnt < PMAX)) m_cnt++;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_left--;
          m_done = 1'b0;
        end
      end else begin
        m_done = 1'b0;
        if (md && !st) begin
          m_busy = 1'b1;
          m_left = MD_LAT;
        end
      end
    end
    #1;
  endtask

  initial begin
    // Reset state
    clrn = 1'b0;
    clear_in();
    #2;
    push("rst_fwda", S_FWDA, 32'd0);
    push("rst_fwdb", S_FWDB, 32'd0);
    push("rst_wpcir", S_WPCIR, 32'd1);
    push("rst_bubble", S_BUBL, 32'd0);
    push("rst_busy", S_BUSY, 32'd0);
    push("rst_done", S_DONE, 32'd0);
    push("rst_scnt", S_SCNT, 32'd0);
    drain();
    tick();
    tick();
    clrn = 1'b1;

    // EX ALU forward on rs
    tick();
    clear_in();
    ewreg = 1'b1; ern = 5'd5; rs = 5'd5; use_rs = 1'b1;
    #3;
    push("t1_fwda", S_FWDA, 32'h1);
    push("t1_wpcir", S_WPCIR, 32'd1);
    drain();

    // EX and MEM both write r7: EX wins
    tick();
    clear_in();
    ewreg = 1'b1; ern = 5'd7; mwreg = 1'b1; mrn = 5'd7; rt = 5'd7; use_rt = 1'b1;
    #3;
    push("t2_fwdb_exwins", S_FWDB, 32'h1);
    drain();

    // r0 never forwarded
    tick();
    clear_in();
    ewreg = 1'b1; ern = 5'd0; rs = 5'd0; use_rs = 1'b1;
    #3;
    push("t2_fwda_r0", S_FWDA, 32'h0);
    push("t2_wpcir_r0", S_WPCIR, 32'd1);
    drain();

    // MEM ALU forward, then MEM load forward without stall
    tick();
    clear_in();
    mwreg = 1'b1; mrn = 5'd9; rs = 5'd9; use_rs = 1'b1;
    #3;
    push("t2_fwda_mem_alu", S_FWDA, 32'h2);
    drain();
    mm2reg = 1'b1;
    #1;
    push("t2_fwda_mem_ld", S_FWDA, 32'h3);
    push("t2_wpcir_mem_ld", S_WPCIR, 32'd1);
    drain();

    // Load-use: one stall cycle, then forward from MEM load data
    tick();
    clear_in();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3; rt = 5'd3; use_rt = 1'b1;
    #3;
    push("t3_lu_wpcir", S_WPCIR, 32'd0);
    push("t3_lu_bubble", S_BUBL, 32'd1);
    push("t3_lu_fwdb", S_FWDB, 32'h0);
    drain();
    tick();
    clear_in();
    mwreg = 1'b1; mm2reg = 1'b1; mrn = 5'd3; rt = 5'd3; use_rt = 1'b1;
    #3;
    push("t3_fwdb_ld", S_FWDB, 32'h3);
    push("t3_wpcir", S_WPCIR, 32'd1);
    push("t3_scnt", S_SCNT, 32'd1);
    push_model("t3_m");
    drain();

    // Mul/div issue; ALU ops run freely, HI/LO read stalls until exit,
    // a start held on the exit edge issues on the next cycle.
    tick();
    clear_in();
    d_md = 1'b1;
    #3;
    push("t4_issue_wpcir", S_WPCIR, 32'd1);
    push("t4_issue_busy", S_BUSY, 32'd0);
    drain();
    for (int c = 1; c <= 10; c++) begin
      tick();
      clear_in();
      if (c <= 2) begin
        ewreg = 1'b1; ern = 5'd4; rs = 5'd4; use_rs = 1'b1;
      end else if (c <= 9) begin
        d_mdrd = 1'b1;
      end
      if ((c == 8) || (c == 9)) d_md = 1'b1;
      #3;
      push($sformatf("t4_busy_c%0d", c), S_BUSY, 32'((c <= 8) || (c == 10)));
      push($sformatf("t4_done_c%0d", c), S_DONE, 32'(c == 9));
      push($sformatf("t4_wpcir_c%0d", c), S_WPCIR, 32'(!((c >= 3) && (c <= 8))));
      push($sformatf("t4_bubble_c%0d", c), S_BUBL, 32'((c >= 3) && (c <= 8)));
      push_model($sformatf("t4_m_c%0d", c));
      drain();
    end

    // Reset at busy cycle 3 of the second operation
    tick();
    tick();
    clear_in();
    clrn = 1'b0;
    model_reset();
    #1;
    push("t5_async_busy", S_BUSY, 32'd0);
    push("t5_async_done", S_DONE, 32'd0);
    push("t5_async_scnt", S_SCNT, 32'd0);
    push("t5_async_wpcir", S_WPCIR, 32'd1);
    drain();
    tick();
    tick();
    clrn = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      #3;
      push($sformatf("t5_nodone_c%0d", c), S_DONE, 32'd0);
      push($sformatf("t5_idle_c%0d", c), S_BUSY, 32'd0);
      drain();
    end
    d_md = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      clear_in();
      #3;
      push($sformatf("t5_busy_c%0d", c), S_BUSY, 32'(c <= 8));
      push($sformatf("t5_done_c%0d", c), S_DONE, 32'(c == 9));
      push_model($sformatf("t5_m_c%0d", c));
      drain();
    end

    // Saturation of the stall counter
    tick();
    clear_in();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3; rs = 5'd3; use_rs = 1'b1;
    for (int i = 1; i <= (1 << PERFW) + 5; i++) begin
      tick();
      #3;
      push($sformatf("t6_wpcir_%0d", i), S_WPCIR, 32'd0);
      push_model($sformatf("t6_m_%0d", i));
      drain();
    end
    push("t6_scnt_sat", S_SCNT, 32'hF);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
